lcd_bcd_writer: RTL and testbench
=================================

# lcd_bcd_writer

Display stage downstream of the binary-to-BCD converter. Takes the three BCD digits (hundreds, tens, ones) and drives an HD44780-compatible character LCD over its 8-bit parallel bus. After reset it runs the LCD power-up/init command sequence. From then on it rewrites the three digit characters at a fixed DDRAM position whenever the digit triple changes.

## Interface
- `E_HIGH_CYCLES`, default 25: cycles `lcd_e` is held high per bus write (≥1).
- `CMD_WAIT_CYCLES`, default 2500: cycles `lcd_e` is held low after a normal write (≥1).
- `CLEAR_WAIT_CYCLES`, default 100000: cycles `lcd_e` is held low after the clear command.
- `POWERUP_CYCLES`, default 1000000: idle cycles after reset before the first command.
- `DDRAM_ADDR`, default 7'h00: DDRAM address of the hundreds character. Tens is at +1, ones at +2.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `H` in 4: hundreds BCD digit.
- `T` in 4: tens BCD digit.
- `O` in 4: ones BCD digit.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: constant 0 (write only).
- `lcd_e` out 1: LCD enable strobe.
- `lcd_data` out 8: LCD data bus.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
**Reset values:** `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00, `busy`=1, snapshot invalid.

**Bus write (shared by all transactions):**
- Cycle 0: drive `lcd_rs`/`lcd_data`, `lcd_e`=0 (setup).
- Next `E_HIGH_CYCLES` cycles: `lcd_e`=1.
- Then `lcd_e`=0 for the wait count: `CLEAR_WAIT_CYCLES` for 0x01, otherwise `CMD_WAIT_CYCLES`.
- `lcd_rs`/`lcd_data` stay stable through the whole transaction.

**FSM states and transitions:**
- PWRUP: count `POWERUP_CYCLES`, then go to INIT.
- INIT: write the commands 0x38, 0x0C, 0x06, 0x01 in order, `rs`=0.
- IDLE: `busy`=0. Each cycle compare {H,T,O} against the snapshot. If they differ, or the snapshot is invalid, latch {H,T,O} into the snapshot, mark it valid and go to SET_ADDR. Otherwise stay in IDLE.
- SET_ADDR: write command 0x80 | `DDRAM_ADDR`.
- WR_H → WR_T → WR_O: `rs`=1 data writes of the converted characters from the snapshot, then return to IDLE.

**Digit conversion:**
- Digit 0–9 maps to 8'h30 + digit.
- Digit 10–15 maps to 8'h3F ('?').

**Boundary behaviour:**
- All three inputs are sampled in the same cycle. No partial triples.
- Input changes while `busy`=1 are not queued. Only the value present on return to IDLE is compared, so the display always converges to the latest triple.
- Because the snapshot is invalid after reset, the first pass after INIT always writes the digits.
- Reset asserted mid-transaction: `lcd_e` falls asynchronously and the FSM restarts at PWRUP.

## Timing
- One bus write takes 1 + `E_HIGH_CYCLES` + wait cycles.
- Reset to first `lcd_e` rise: `POWERUP_CYCLES` + 1 cycles.
- IDLE detect to SET_ADDR setup cycle: 1 cycle.
- Full digit update: 4 × (1 + `E_HIGH_CYCLES` + `CMD_WAIT_CYCLES`) cycles, after which `busy` falls.
- `busy` falls in the same cycle as state = IDLE.
- Registered outputs only; no combinational path from `H`/`T`/`O` to the LCD pins.

## Configuration
- Macro: `LCD_LEADING_ZERO_BLANK_EN`.
- Defined:
  - Hundreds digit 0 is written as 8'h20 (space).
  - Tens digit 0 is written as 8'h20 when hundreds is also 0.
  - The ones digit is always shown.
- Undefined: all three digits are always written as characters.
- Blanking applies only to value 0. Invalid digits still map to '?'.

## Structure
- Package `lcd_pkg`:
  - Command constants: `LCD_FUNC_SET`=8'h38, `LCD_DISP_ON`=8'h0C, `LCD_ENTRY`=8'h06, `LCD_CLEAR`=8'h01, `LCD_SET_DDRAM`=8'h80.
  - `ASCII_ZERO`=8'h30, `ASCII_SPACE`=8'h20, `ASCII_QMARK`=8'h3F.
  - FSM state enum.
- Sub-module `lcd_bus_cycle`:
  - Implements one bus write with a start/done handshake: `start` pulse with `rs`/`data`/`long_wait` in, `done` 1-cycle pulse out.
  - Owns the `lcd_e` timing counters.
  - The top FSM only sequences transactions.

## Test plan
All tests use sim parameters: `E_HIGH_CYCLES`=2, `CMD_WAIT_CYCLES`=4, `CLEAR_WAIT_CYCLES`=8, `POWERUP_CYCLES`=10, `DDRAM_ADDR`=0.
- **Init sequence:** release `rst_n` with H/T/O = 1/2/8.
  - `lcd_e` stays low for 10 cycles.
  - Commands 0x38, 0x0C, 0x06, 0x01 with `rs`=0, each `e` pulse exactly 2 cycles wide; 8-cycle gap after 0x01.
  - Then 0x80 (`rs`=0), followed by 0x31, 0x32, 0x38 (`rs`=1); `busy`→0.
- **Single change:** change to 2/5/5 while idle → 0x80, 0x32, 0x35, 0x35; each write spans 7 cycles.
- **Change while busy:** 1/2/8 → 2/5/5 → 0/4/2 while `busy` → the final written characters are 0x30 (or 0x20 with the macro), 0x34, 0x32; no extra sequence afterwards.
- **Leading-zero blanking:** 0/0/7 with the macro → 0x20, 0x20, 0x37; without → 0x30, 0x30, 0x37.
- **Invalid digit:** H=4'hA → hundreds character 0x3F.
- **Reset mid-write:** assert `rst_n` while `lcd_e`=1 → `lcd_e`=0 in the same cycle; after release the full PWRUP/INIT sequence repeats.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the BCD-to-LCD display stage.
// HD44780 command bytes and ASCII codes used by the writer and its bus engine.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SET_ADDR,
        ST_WR_H,
        ST_WR_T,
        ST_WR_O
    } lcd_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_HIGH,
        B_LOW
    } bus_state_t;

    function automatic logic [7:0] bcd_char(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = LCD_FUNC_SET;
            2'd1:    c = LCD_DISP_ON;
            2'd2:    c = LCD_ENTRY;
            default: c = LCD_CLEAR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 parallel-bus write: setup cycle, E high window, E low wait.
// A new start is accepted while idle or in the final wait cycle (done).
module lcd_bus_cycle import lcd_pkg::*; #(
    parameter int unsigned E_HIGH_CYCLES     = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    bus_state_t  bstate;
    logic [31:0] cnt;
    logic        long_q;
    logic [31:0] wait_len;

    assign wait_len = long_q ? CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
    assign done     = (bstate == B_LOW) && (cnt == wait_len - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate   <= B_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (start && (bstate == B_IDLE || done)) begin
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_wait;
            lcd_e    <= 1'b0;
            cnt      <= '0;
            bstate   <= B_SETUP;
        end else begin
            unique case (bstate)
                B_SETUP: begin
                    lcd_e  <= 1'b1;
                    cnt    <= '0;
                    bstate <= B_HIGH;
                end
                B_HIGH: begin
                    if (cnt == E_HIGH_CYCLES - 1) begin
                        lcd_e  <= 1'b0;
                        cnt    <= '0;
                        bstate <= B_LOW;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                B_LOW: begin
                    if (done) bstate <= B_IDLE;
                    else      cnt    <= cnt + 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bcd_writer.sv
// Drives three BCD digits onto an HD44780 LCD; inits after reset, rewrites on change.
// LCD_LEADING_ZERO_BLANK_EN: show leading zeros of hundreds/tens as spaces.
module lcd_bcd_writer import lcd_pkg::*; #(
    parameter int unsigned E_HIGH_CYCLES     = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000,
    parameter int unsigned POWERUP_CYCLES    = 1000000,
    parameter logic [6:0]  DDRAM_ADDR        = 7'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] H,
    input  logic [3:0] T,
    input  logic [3:0] O,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy
);

    lcd_state_t  state;
    logic [31:0] pcnt;
    logic [1:0]  init_idx;
    logic [11:0] snap;
    logic        snap_valid;
    logic [11:0] digits;
    logic        change;
    logic        start;
    logic        cmd_rs;
    logic        cmd_long;
    logic [7:0]  cmd_data;
    logic        done;
    logic [7:0]  ch_h;
    logic [7:0]  ch_t;
    logic [7:0]  ch_o;

    assign lcd_rw = 1'b0;
    assign digits = {H, T, O};
    assign change = !snap_valid || (digits != snap);

`ifdef LCD_LEADING_ZERO_BLANK_EN
    assign ch_h = (snap[11:8] == 4'd0) ? ASCII_SPACE : bcd_char(snap[11:8]);
    assign ch_t = (snap[11:4] == 8'd0) ? ASCII_SPACE : bcd_char(snap[7:4]);
`else
    assign ch_h = bcd_char(snap[11:8]);
    assign ch_t = bcd_char(snap[7:4]);
`endif
    assign ch_o = bcd_char(snap[3:0]);

    // Next transaction is launched in the final cycle of the current one.
    always_comb begin
        start    = 1'b0;
        cmd_rs   = 1'b0;
        cmd_data = 8'h00;
        unique case (state)
            ST_PWRUP: begin
                if (pcnt == POWERUP_CYCLES - 1) begin
                    start    = 1'b1;
                    cmd_data = init_cmd(2'd0);
                end
            end
            ST_INIT: begin
                if (done && init_idx != 2'd3) begin
                    start    = 1'b1;
                    cmd_data = init_cmd(init_idx + 2'd1);
                end
            end
            ST_IDLE: begin
                if (change) begin
                    start    = 1'b1;
                    cmd_data = LCD_SET_DDRAM | {1'b0, DDRAM_ADDR};
                end
            end
            ST_SET_ADDR: begin
                start    = done;
                cmd_rs   = 1'b1;
                cmd_data = ch_h;
            end
            ST_WR_H: begin
                start    = done;
                cmd_rs   = 1'b1;
                cmd_data = ch_t;
            end
            ST_WR_T: begin
                start    = done;
                cmd_rs   = 1'b1;
                cmd_data = ch_o;
            end
            default: ;
        endcase
    end

    assign cmd_long = !cmd_rs && (cmd_data == LCD_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PWRUP;
            pcnt       <= '0;
            init_idx   <= 2'd0;
            snap       <= '0;
            snap_valid <= 1'b0;
            busy       <= 1'b1;
        end else begin
            unique case (state)
                ST_PWRUP: begin
                    if (pcnt == POWERUP_CYCLES - 1) begin
                        state    <= ST_INIT;
                        init_idx <= 2'd0;
                    end else begin
                        pcnt <= pcnt + 1;
                    end
                end
                ST_INIT: begin
                    if (done) begin
                        if (init_idx == 2'd3) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (change) begin
                        snap       <= digits;
                        snap_valid <= 1'b1;
                        state      <= ST_SET_ADDR;
                        busy       <= 1'b1;
                    end
                end
                ST_SET_ADDR: if (done) state <= ST_WR_H;
                ST_WR_H:     if (done) state <= ST_WR_T;
                ST_WR_T:     if (done) state <= ST_WR_O;
                ST_WR_O: begin
                    if (done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_PWRUP;
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_HIGH_CYCLES     (E_HIGH_CYCLES),
        .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_bus (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rs        (cmd_rs),
        .data      (cmd_data),
        .long_wait (cmd_long),
        .done      (done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data)
    );

endmodule

// File: tb/tb_lcd_bcd_writer.sv
// Bench for lcd_bcd_writer: bus-write monitor, vector table, random triples vs model.
module tb_lcd_bcd_writer;

    localparam int E_HI = 2;
    localparam int CMD_W = 4;
    localparam int CLR_W = 8;
    localparam int PWR = 10;
    localparam int WR_LEN = 1 + E_HI + CMD_W;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] H, T, O;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [7:0] lcd_data;

    lcd_bcd_writer #(
        .E_HIGH_CYCLES     (E_HI),
        .CMD_WAIT_CYCLES   (CMD_W),
        .CLEAR_WAIT_CYCLES (CLR_W),
        .POWERUP_CYCLES    (PWR),
        .DDRAM_ADDR        (7'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .H        (H),
        .T        (T),
        .O        (O),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         width;
    } rec_t;

    typedef struct {
        logic [3:0] h, t, o;
        logic [7:0] eh, et, eo;
    } vec_t;

    rec_t wlog[$];
    int   cyc = 0;
    int   stab_err = 0;
    logic e_prev = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every E pulse: rs/data at rise, width at fall, data stability while high.
    always @(negedge clk) begin
        rec_t r;
        int   n;
        n = wlog.size();
        if (lcd_e && !e_prev) begin
            r.rs = lcd_rs;
            r.data = lcd_data;
            r.rise = cyc;
            r.width = 0;
            wlog.push_back(r);
        end else if (lcd_e && n > 0) begin
            if (lcd_data !== wlog[n-1].data || lcd_rs !== wlog[n-1].rs)
                stab_err = stab_err + 1;
        end
        if (!lcd_e && e_prev && n > 0)
            wlog[n-1].width = cyc - wlog[n-1].rise;
        e_prev = lcd_e;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_char(input int d, input bit blank);
        if (blank) return 8'h20;
        if (d < 10) return 8'(48 + d);
        return 8'h3F;
    endfunction

    task automatic check_digits(input string tag, input int base,
                                input logic [7:0] eh, input logic [7:0] et,
                                input logic [7:0] eo);
        chk({tag, "_addr"}, {wlog[base].rs, wlog[base].data}, {1'b0, 8'h80});
        chk({tag, "_h"}, {wlog[base+1].rs, wlog[base+1].data}, {1'b1, eh});
        chk({tag, "_t"}, {wlog[base+2].rs, wlog[base+2].data}, {1'b1, et});
        chk({tag, "_o"}, {wlog[base+3].rs, wlog[base+3].data}, {1'b1, eo});
    endtask

    task automatic release_and_check_init(input string tag);
        int rel;
        logic [7:0] icmd [4];
        icmd[0] = 8'h38; icmd[1] = 8'h0C; icmd[2] = 8'h06; icmd[3] = 8'h01;
        wlog.delete();
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(PWR + 4 * WR_LEN + CLR_W + 4 * WR_LEN + 20);
        chk({tag, "_nwrites"}, wlog.size(), 8);
        chk({tag, "_first_rise"}, wlog[0].rise - rel, PWR + 1);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_cmd"}, {wlog[i].rs, wlog[i].data}, {1'b0, icmd[i]});
            chk({tag, "_ewidth"}, wlog[i].width, E_HI);
        end
        for (int i = 1; i < 4; i++)
            chk({tag, "_span"}, wlog[i].rise - wlog[i-1].rise, WR_LEN);
        chk({tag, "_clear_gap"}, wlog[4].rise - wlog[3].rise - wlog[3].width, CLR_W + 2);
        check_digits(tag, 4, 8'h31, 8'h32, 8'h38);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    vec_t vecs [8];

    initial begin
        int k;
        int ph, pt, po, nh, nt, no;
        logic [7:0] eh, et, eo;

        vecs[0] = '{4'h2, 4'h5, 4'h5, 8'h32, 8'h35, 8'h35};
        vecs[1] = '{4'h0, 4'h0, 4'h7, LZ ? 8'h20 : 8'h30, LZ ? 8'h20 : 8'h30, 8'h37};
        vecs[2] = '{4'hA, 4'h3, 4'h4, 8'h3F, 8'h33, 8'h34};
        vecs[3] = '{4'h0, 4'hA, 4'h1, LZ ? 8'h20 : 8'h30, 8'h3F, 8'h31};
        vecs[4] = '{4'h9, 4'h0, 4'h0, 8'h39, 8'h30, 8'h30};
        vecs[5] = '{4'h0, 4'h0, 4'h0, LZ ? 8'h20 : 8'h30, LZ ? 8'h20 : 8'h30, 8'h30};
        vecs[6] = '{4'hF, 4'hF, 4'hF, 8'h3F, 8'h3F, 8'h3F};
        vecs[7] = '{4'h0, 4'h4, 4'h2, LZ ? 8'h20 : 8'h30, 8'h34, 8'h32};

        rst_n = 1'b0;
        H = 4'd1; T = 4'd2; O = 4'd8;
        wait_cyc(3);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_busy", busy, 1'b1);

        release_and_check_init("init");

        foreach (vecs[i]) begin
            wlog.delete();
            H = vecs[i].h; T = vecs[i].t; O = vecs[i].o;
            wait_cyc(1);
            k = 1;
            while (busy && k < 100) begin
                wait_cyc(1);
                k++;
            end
            chk("vec_busy_len", k, 1 + 4 * WR_LEN);
            chk("vec_nwrites", wlog.size(), 4);
            check_digits("vec", 0, vecs[i].eh, vecs[i].et, vecs[i].eo);
            for (int j = 1; j < 4; j++)
                chk("vec_span", wlog[j].rise - wlog[j-1].rise, WR_LEN);
        end

        H = 4'd1; T = 4'd2; O = 4'd8;
        wait_cyc(40);
        wlog.delete();
        H = 4'd2; T = 4'd5; O = 4'd5;
        wait_cyc(3);
        chk("cwb_busy", busy, 1'b1);
        H = 4'd0; T = 4'd4; O = 4'd2;
        wait_cyc(80);
        chk("cwb_nwrites", wlog.size(), 8);
        check_digits("cwb_first", 0, 8'h32, 8'h35, 8'h35);
        check_digits("cwb_last", 4, LZ ? 8'h20 : 8'h30, 8'h34, 8'h32);
        wait_cyc(30);
        chk("cwb_no_extra", wlog.size(), 8);
        chk("cwb_idle", busy, 1'b0);

        ph = 0; pt = 4; po = 2;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                nh = ph; nt = pt; no = po;
            end else begin
                nh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
                nt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
                no = $urandom_range(0, 15);
            end
            wlog.delete();
            H = 4'(nh); T = 4'(nt); O = 4'(no);
            wait_cyc(40);
            chk("rnd_idle", busy, 1'b0);
            if (nh == ph && nt == pt && no == po) begin
                chk("rnd_nowrite", wlog.size(), 0);
            end else begin
                eh = ref_char(nh, LZ && nh == 0);
                et = ref_char(nt, LZ && nh == 0 && nt == 0);
                eo = ref_char(no, 1'b0);
                chk("rnd_nwrites", wlog.size(), 4);
                check_digits("rnd", 0, eh, et, eo);
            end
            ph = nh; pt = nt; po = no;
        end

        H = 4'd7; T = 4'd7; O = 4'd7;
        k = 0;
        while (!lcd_e && k < 50) begin
            wait_cyc(1);
            k++;
        end
        chk("midrst_e_seen", lcd_e, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_e_low", lcd_e, 1'b0);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_data", lcd_data, 8'h00);
        wait_cyc(3);
        H = 4'd1; T = 4'd2; O = 4'd8;
        release_and_check_init("reinit");

        chk("bus_stable", stab_err, 0);
        chk("rw_const", lcd_rw, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
